// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with an IDLE/ADDR/DATA transaction FSM, round-robin
// arbitration and bounded bus locking. Define BUS_ARB_FIXED_PRIO_EN for fixed priority (master 0 wins ties).
module bus_arbiter #(
  parameter int LOCK_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_we,
  input  logic        m1_we,
  input  logic        m0_lock,
  input  logic        m1_lock,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  output logic        m0_ack,
  output logic        m1_ack,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_we,
  input  logic [31:0] bus_rdata,
  output logic        owner,
  output logic        bus_busy
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t        state_q;
  logic          owner_q;
  logic          last_q;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [CW-1:0] lock_cnt_q;

  logic          done;
  logic          start;
  logic          tie_winner;
  logic          grant_d;
  logic [CW-1:0] lock_cnt_d;
  logic          owner_req;
  logic          owner_lock;
  logic          other_req;

`ifdef BUS_ARB_FIXED_PRIO_EN
  assign tie_winner = 1'b0;
`else
  assign tie_winner = ~last_q;
`endif

  assign done       = ((state_q == ADDR) && we_q) || (state_q == DATA);
  assign start      = (m0_req || m1_req) && ((state_q == IDLE) || done);
  assign owner_req  = owner_q ? m1_req  : m0_req;
  assign owner_lock = owner_q ? m1_lock : m0_lock;
  assign other_req  = owner_q ? m0_req  : m1_req;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    lock_cnt_d = '0;
    grant_d    = (m0_req && m1_req) ? tie_winner : m1_req;
    if (done && owner_lock && owner_req) begin
      lock_cnt_d = (lock_cnt_q == CW'(LOCK_MAX)) ? lock_cnt_q : lock_cnt_q + CW'(1);
      if ((lock_cnt_d == CW'(LOCK_MAX)) && other_req) begin
        grant_d    = ~owner_q;
        lock_cnt_d = '0;
      end else begin
        grant_d    = owner_q;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      lock_cnt_q <= '0;
    end else begin
      if (start) begin
        state_q <= ADDR;
        owner_q <= grant_d;
        last_q  <= grant_d;
        we_q    <= grant_d ? m1_we    : m0_we;
        addr_q  <= grant_d ? m1_addr  : m0_addr;
        wdata_q <= grant_d ? m1_wdata : m0_wdata;
      end else if ((state_q == ADDR) && !we_q) begin
        state_q <= DATA;
      end else if (done) begin
        state_q <= IDLE;
      end
      if (done) begin
        lock_cnt_q <= lock_cnt_d;
      end
    end
  end

  // Payload is captured at grant, so a master dropping req mid-transaction cannot corrupt it.
  assign bus_busy  = (state_q != IDLE);
  assign bus_addr  = bus_busy ? addr_q  : '0;
  assign bus_wdata = bus_busy ? wdata_q : '0;
  assign bus_we    = (state_q == ADDR) && we_q;
  assign owner     = owner_q;
  assign m0_ack    = done && !owner_q;
  assign m1_ack    = done && owner_q;
  assign m0_rdata  = ((state_q == DATA) && !owner_q) ? bus_rdata : '0;
  assign m1_rdata  = ((state_q == DATA) && owner_q)  ? bus_rdata : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_bus_arbiter;

  localparam int LOCK_MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req, m0_we, m1_we, m0_lock, m1_lock;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_we, owner, bus_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
    .m0_lock(m0_lock), .m1_lock(m1_lock),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_ack(m0_ack), .m1_ack(m1_ack), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_rdata(bus_rdata),
    .owner(owner), .bus_busy(bus_busy)
  );

  // Contents of a location never written: 0x2000 is the switch register.
  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a == 32'h2000) ? 32'h0000_00A5 : ~a;
  endfunction

  // Memory-map environment: synchronous RAM, read data one cycle after address.
  logic [31:0] env_mem [64];
  logic [63:0] env_wr = '0;
  always @(posedge clk) begin
    if (bus_we) begin
      env_mem[bus_addr[7:2]] <= bus_wdata;
      env_wr[bus_addr[7:2]]  <= 1'b1;
    end
    bus_rdata <= env_wr[bus_addr[7:2]] ? env_mem[bus_addr[7:2]] : init_val(bus_addr);
  end

  // Reference model: current transaction, remaining cycles to its ack, lock tenure.
  logic [31:0] ref_mem [logic [31:0]];
  bit          m_busy, m_first, m_we;
  int          m_owner, m_last, m_left, m_tenure;
  logic [31:0] m_addr, m_wdata;
  int          obs_ack;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_first = 0; m_we = 0;
    m_owner = 0; m_last = 1; m_left = 0; m_tenure = 0;
    m_addr = '0; m_wdata = '0;
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic model_check();
    bit          ack;
    logic [31:0] rd;
    ack = m_busy && (m_left == 0);
    rd  = (ack && !m_we) ? ref_read(m_addr) : 32'h0;
    check("bus_busy", 32'(bus_busy), 32'(m_busy));
    check("owner",    32'(owner),    32'(m_owner));
    check("bus_addr", bus_addr, m_busy ? m_addr : 32'h0);
    check("bus_we",   32'(bus_we),   32'(m_busy && m_first && m_we));
    if (!m_busy || m_first)
      check("bus_wdata", bus_wdata, m_busy ? m_wdata : 32'h0);
    check("m0_ack",   32'(m0_ack),   32'(ack && (m_owner == 0)));
    check("m1_ack",   32'(m1_ack),   32'(ack && (m_owner == 1)));
    check("m0_rdata", m0_rdata, (m_owner == 0) ? rd : 32'h0);
    check("m1_rdata", m1_rdata, (m_owner == 1) ? rd : 32'h0);
    obs_ack = m0_ack ? 0 : (m1_ack ? 1 : -1);
    if (ack && m_we) ref_mem[m_addr] = m_wdata;
  endtask

  // Advance the model across one clock edge using the inputs the DUT is about to sample.
  task automatic model_next();
    bit done, own_req, own_lock, oth_req;
    int nxt;
    done     = m_busy && (m_left == 0);
    own_req  = (m_owner == 1) ? m1_req  : m0_req;
    own_lock = (m_owner == 1) ? m1_lock : m0_lock;
    oth_req  = (m_owner == 1) ? m0_req  : m1_req;
    if (m_busy && !done) begin
      m_left  = m_left - 1;
      m_first = 0;
    end else begin
      nxt = -1;
      if (done && own_lock && own_req) begin
        if (m_tenure < LOCK_MAX) m_tenure = m_tenure + 1;
        if ((m_tenure >= LOCK_MAX) && oth_req) begin
          nxt = 1 - m_owner;
          m_tenure = 0;
        end else begin
          nxt = m_owner;
        end
      end else begin
        m_tenure = 0;
        if (m0_req && m1_req) begin
`ifdef BUS_ARB_FIXED_PRIO_EN
          nxt = 0;
`else
          nxt = 1 - m_last;
`endif
        end else if (m0_req) nxt = 0;
        else if (m1_req) nxt = 1;
      end
      if (nxt < 0) begin
        m_busy  = 0;
        m_first = 0;
      end else begin
        m_busy  = 1;
        m_first = 1;
        m_owner = nxt;
        m_last  = nxt;
        m_we    = (nxt == 1) ? m1_we    : m0_we;
        m_addr  = (nxt == 1) ? m1_addr  : m0_addr;
        m_wdata = (nxt == 1) ? m1_wdata : m0_wdata;
        m_left  = m_we ? 0 : 1;
      end
    end
  endtask

  task automatic cycle();
    model_next();
    @(posedge clk);
    @(negedge clk);
    model_check();
  endtask

  task automatic m0_set(input logic r, input logic w, input logic l,
                        input logic [31:0] a, input logic [31:0] d);
    m0_req = r; m0_we = w; m0_lock = l; m0_addr = a; m0_wdata = d;
  endtask

  task automatic m1_set(input logic r, input logic w, input logic l,
                        input logic [31:0] a, input logic [31:0] d);
    m1_req = r; m1_we = w; m1_lock = l; m1_addr = a; m1_wdata = d;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    m0_set(0, 0, 0, '0, '0);
    m1_set(0, 0, 0, '0, '0);
    model_reset();
    #1;
    model_check();
    @(negedge clk);
    reset = 1'b1;
  endtask

  logic [31:0] addrs [4] = '{32'h10, 32'h14, 32'h18, 32'h1C};
  int          exp_lock_seq [6] = '{1, 1, 1, 1, 0, 1};

  initial begin
    apply_reset();

    // Write then read back through master 0.
    m0_set(1, 1, 0, 32'h1004, 32'hDEAD_BEEF);
    cycle();
    check("wr_bus_we",    32'(bus_we), 32'd1);
    check("wr_bus_addr",  bus_addr,  32'h1004);
    check("wr_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
    check("wr_ack_+1",    32'(m0_ack), 32'd1);
    m0_set(0, 0, 0, 32'h1004, '0);
    cycle();
    check("wr_idle_we", 32'(bus_we), 32'd0);
    m0_set(1, 0, 0, 32'h1004, '0);
    cycle();
    check("rd_no_ack_+1", 32'(m0_ack), 32'd0);
    cycle();
    check("rd_ack_+2",  32'(m0_ack), 32'd1);
    check("rd_data_+2", m0_rdata, 32'hDEAD_BEEF);
    m0_set(0, 0, 0, '0, '0);
    cycle();
    check("rd_rdata_idle", m0_rdata, 32'h0);

    // Switch read; req dropped and addr changed after grant must not abort it.
    m0_set(1, 0, 0, 32'h2000, '0);
    cycle();
    check("sw_we_addr", 32'(bus_we), 32'd0);
    m0_set(0, 0, 0, 32'h3000, '0);
    cycle();
    check("sw_ack",     32'(m0_ack), 32'd1);
    check("sw_rdata",   m0_rdata, 32'h0000_00A5);
    check("sw_we_data", 32'(bus_we), 32'd0);
    cycle();

    // Both masters reading persistently: alternating grants, acks 2 cycles apart.
    apply_reset();
    m0_set(1, 0, 0, 32'h10, '0);
    m1_set(1, 0, 0, 32'h14, '0);
    for (int c = 1; c <= 8; c++) begin
      cycle();
      check($sformatf("rr_ack0_c%0d", c), 32'(m0_ack), 32'((c == 2) || (c == 6)));
      check($sformatf("rr_ack1_c%0d", c), 32'(m1_ack), 32'((c == 4) || (c == 8)));
    end
    m0_set(0, 0, 0, '0, '0);
    m1_set(0, 0, 0, '0, '0);
    cycle();
    cycle();

`ifndef BUS_ARB_FIXED_PRIO_EN
    // Master 1 locking with master 0 waiting: LOCK_MAX master-1 writes, then master 0.
    apply_reset();
    m1_set(1, 1, 1, 32'h18, 32'h1111_0000);
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (k == 0) m0_set(1, 1, 0, 32'h1C, 32'h2222_0000);
      check($sformatf("lock_seq_%0d", k), 32'(obs_ack), 32'(exp_lock_seq[k]));
    end
    m0_set(0, 0, 0, '0, '0);
    m1_set(0, 0, 0, '0, '0);
    cycle();
    cycle();
`endif

    // Reset asserted during the DATA cycle of a master-0 read.
    m0_set(1, 0, 0, 32'h10, '0);
    cycle();
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_m0_ack",   32'(m0_ack), 32'd0);
    check("rst_m0_rdata", m0_rdata, 32'h0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_we",   32'(bus_we), 32'd0);
    check("rst_busy",     32'(bus_busy), 32'd0);
    check("rst_owner",    32'(owner), 32'd0);
    model_reset();
    m0_set(0, 0, 0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    cycle();
    check("rst_idle_after", 32'(bus_busy), 32'd0);

`ifdef BUS_ARB_FIXED_PRIO_EN
    // Fixed priority: master 0 wins every transaction while both request.
    apply_reset();
    m0_set(1, 0, 0, 32'h10, '0);
    m1_set(1, 0, 0, 32'h14, '0);
    for (int c = 1; c <= 12; c++) begin
      cycle();
      check($sformatf("fp_ack1_c%0d", c), 32'(m1_ack), 32'd0);
      check($sformatf("fp_ack0_c%0d", c), 32'(m0_ack), 32'((c % 2) == 0));
    end
    m0_set(0, 0, 0, '0, '0);
    m1_set(0, 0, 0, '0, '0);
    cycle();
`endif

    // Randomized traffic; each master holds its request until acked.
    apply_reset();
    for (int n = 0; n < 1500; n++) begin
      if (!m0_req || m0_ack) begin
        if ($urandom_range(0, 9) < 6)
          m0_set(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                 addrs[$urandom_range(0, 3)], $urandom);
        else
          m0_req = 1'b0;
      end
      if (!m1_req || m1_ack) begin
        if ($urandom_range(0, 9) < 6)
          m1_set(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                 addrs[$urandom_range(0, 3)], $urandom);
        else
          m1_req = 1'b0;
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
